// File: rtl/ram_bist_if.sv
// RAM port bundle between the BIST controller (master) and the memory under test (slave).
interface ram_bist_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_din,
        input  ram_dout
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// March-style RAM self test: write pat0 ascending, read ascending, write pat1 descending,
// read descending. Reads are checked through a one-cycle compare pipeline.
module ram_bist_ctrl #(
    parameter int unsigned          ADDR_W = 4,
    parameter int unsigned          DATA_W = 8,
    parameter logic [DATA_W-1:0]    SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    ram_bist_if.master        ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {
        StIdle, StWrUp, StRdUp, StWrDn, StRdDn, StFin, StDone
    } state_e;

    localparam logic [ADDR_W-1:0] AddrMax = '1;

    function automatic logic [DATA_W-1:0] pat0(input logic [ADDR_W-1:0] a);
        return SEED ^ DATA_W'(a);
    endfunction

    function automatic logic [DATA_W-1:0] pat1(input logic [ADDR_W-1:0] a);
        return ~pat0(a);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic [7:0]        err_q, err_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_q, fail_d;

    logic launch;
    assign launch = start && (state_q == StIdle || state_q == StDone);

    // Sequencer: walks the address through the four march phases.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWrUp;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    din_d   = pat0('0);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            StWrUp: begin
                if (addr_q == AddrMax) begin
                    state_d = StRdUp;
                    addr_d  = '0;
                    we_d    = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    din_d  = pat0(addr_q + 1'b1);
                end
            end
            StRdUp: begin
                if (addr_q == AddrMax) begin
                    state_d = StWrDn;
                    addr_d  = AddrMax;
                    we_d    = 1'b1;
                    din_d   = pat1(AddrMax);
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StWrDn: begin
                if (addr_q == '0) begin
                    state_d = StRdDn;
                    addr_d  = AddrMax;
                    we_d    = 1'b0;
                end else begin
                    addr_d = addr_q - 1'b1;
                    din_d  = pat1(addr_q - 1'b1);
                end
            end
            StRdDn: begin
                if (addr_q == '0) begin
                    state_d = StFin;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            StFin: begin
                // One spare cycle lets the final read's compare land before DONE.
                state_d = StDone;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Checker: register each issued read, compare ram_dout on the following edge.
    always_comb begin
        cmp_valid_d = (state_q == StRdUp) || (state_q == StRdDn);
        cmp_addr_d  = addr_q;
        cmp_exp_d   = (state_q == StRdUp) ? pat0(addr_q) : pat1(addr_q);
        err_d       = err_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        if (launch) begin
            cmp_valid_d = 1'b0;
            err_d       = '0;
            pass_d      = 1'b1;
            fail_d      = '0;
        end else if (cmp_valid_q && (ram.ram_dout != cmp_exp_q)) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            pass_d = 1'b0;
            // pass_q still high means this is the first mismatch of the run.
            if (pass_q) begin
                fail_d = cmp_addr_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
            err_q       <= '0;
            pass_q      <= 1'b0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign ram.ram_we   = we_q;
    assign ram.ram_addr = addr_q;
    assign ram.ram_din  = din_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign fail_addr    = fail_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a synchronous RAM model and selectable faults.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] fail_addr;

    int checks = 0;
    int failures = 0;
    int fault_mode = 0;
    int wr_cnt = 0;

    ram_bist_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .SEED(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model: mode 1 = addr 7 bit 0 stuck at 0, mode 2 = addr 3/9 read 00, mode 3 = reads FF.
    logic [7:0] mem [16];
    logic [7:0] dout_q = 8'h00;
    assign bus.ram_dout = dout_q;

    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= (fault_mode == 1 && bus.ram_addr == 4'd7) ?
                                 (bus.ram_din & 8'hFE) : bus.ram_din;
            wr_cnt <= wr_cnt + 1;
        end else begin
            if (fault_mode == 3)
                dout_q <= 8'hFF;
            else if (fault_mode == 2 && (bus.ram_addr == 4'd3 || bus.ram_addr == 4'd9))
                dout_q <= 8'h00;
            else
                dout_q <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] p0(input int a);
        logic [7:0] s;
        s = 8'hA5;
        return s ^ 8'(a);
    endfunction

    // Pulse start (or leave it high) and return just after the launch edge.
    task automatic launch(input logic hold);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = hold;
    endtask

    // Wait for done with a cycle budget and check result fields.
    task automatic run_fault(input int mode, input int exp_err, input int exp_fail,
                             input logic exp_pass);
        int n;
        fault_mode = mode;
        launch(1'b0);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("m%0d_edges", mode), n, 65);
        check($sformatf("m%0d_err", mode), err_count, exp_err);
        check($sformatf("m%0d_fail", mode), fail_addr, exp_fail);
        check($sformatf("m%0d_pass", mode), pass, exp_pass);
    endtask

    initial begin
        logic [12:0] exp_bus;
        int w0;

        // Reset values
        #1;
        check("rst_state", {busy, done, pass, err_count, fail_addr,
                            bus.ram_we, bus.ram_addr, bus.ram_din}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Good RAM: every access in order, then done at edge 65
        fault_mode = 0;
        launch(1'b0);
        check("launch_flags", {busy, done, pass, err_count, fail_addr}, {3'b101, 8'h00, 4'h0});
        for (int k = 0; k < 64; k++) begin
            int ph, i;
            ph = k / 16;
            i  = k % 16;
            case (ph)
                0:       exp_bus = {1'b1, 4'(i), p0(i)};
                1:       exp_bus = {1'b0, 4'(i), bus.ram_din};
                2:       exp_bus = {1'b1, 4'(15 - i), ~p0(15 - i)};
                default: exp_bus = {1'b0, 4'(15 - i), bus.ram_din};
            endcase
            if (k > 0) @(negedge clk);
            check($sformatf("access%0d", k), {bus.ram_we, bus.ram_addr, bus.ram_din}, exp_bus);
        end
        @(negedge clk);
        check("fin_busy_done", {busy, done}, 2'b10);
        @(negedge clk);
        check("done_flags", {busy, done, bus.ram_we}, 3'b010);
        check("good_result", {pass, err_count, fail_addr}, {1'b1, 8'h00, 4'h0});

        // Fault models, each restarting from DONE
        run_fault(1, 1, 7, 1'b0);
        run_fault(2, 4, 3, 1'b0);
        run_fault(3, 32, 0, 1'b0);

        // start held high: no restart mid-test, restart once in DONE
        fault_mode = 3;
        launch(1'b1);
        repeat (64) @(negedge clk);
        check("hold_fin", {busy, done}, 2'b10);
        @(negedge clk);
        check("hold_done", {busy, done, err_count}, {2'b01, 8'd32});
        @(negedge clk);
        check("hold_restart", {busy, done, err_count, bus.ram_we, bus.ram_addr},
              {2'b10, 8'd0, 1'b1, 4'd0});
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset during WR_DN at addr 10
        fault_mode = 0;
        launch(1'b0);
        repeat (37) @(negedge clk);
        check("wrdn_addr10", {bus.ram_we, bus.ram_addr}, {1'b1, 4'd10});
        rst = 1'b1;
        #1;
        check("abort_async", {bus.ram_we, busy, bus.ram_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_writes", wr_cnt - w0, 0);
        check("abort_idle", {busy, done, pass}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter SEED, default 8'hA5, DATA_W-bit base test pattern.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  launch request, sampled only in IDLE or DONE.
REQ-007 SHALL have port ram_we  output  1  RAM write enable.
REQ-008 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-009 SHALL have port ram_din  output  DATA_W  RAM write data.
REQ-010 SHALL have port ram_dout  input  DATA_W  RAM read data, valid one clock after ram_addr is sampled with ram_we=0.
REQ-011 SHALL have port busy  output  1  test in progress.
REQ-012 SHALL have port done  output  1  test complete; level, held until next start or reset.
REQ-013 SHALL have port pass  output  1  no mismatch found; meaningful only while done=1.
REQ-014 SHALL have port err_count  output  8  mismatch count, saturating at 255.
REQ-015 SHALL have port fail_addr  output  ADDR_W  address of the first mismatch; 0 if none.

Function
REQ-016 SHALL register all outputs; ram_we, ram_addr, ram_din change only on clk edges or async reset.
REQ-017 SHALL implement states IDLE, WR_UP, RD_UP, WR_DN, RD_DN, FIN, DONE.
REQ-018 SHALL define pat0(a) = SEED XOR zero-extended a, and pat1(a) = bitwise NOT pat0(a); e.g. pat0(4)=8'hA1, pat1(4)=8'h5E.
REQ-019 IDLE/DONE + start=1 at edge E0 SHALL enter WR_UP with ram_we=1, ram_addr=0, ram_din=pat0(0), busy=1, done=0, err_count=0, fail_addr=0, pass=1.
REQ-020 WR_UP SHALL issue one write per cycle, addresses 0 up to 2^ADDR_W-1, data pat0(a), then enter RD_UP.
REQ-021 RD_UP SHALL set ram_we=0 and issue one read per cycle, addresses 0 up to max, then enter WR_DN.
REQ-022 WR_DN SHALL write pat1(a) per cycle, addresses max down to 0, then enter RD_DN.
REQ-023 RD_DN SHALL read addresses max down to 0 (ram_we=0), then enter FIN, then DONE.
REQ-024 SHALL compare each read with a 1-cycle pipeline: the issued address and expected value are registered, and ram_dout is compared on the following edge, independent of the current state.
REQ-025 SHALL expect pat0 for RD_UP reads and pat1 for RD_DN reads.
REQ-026 On a mismatch, SHALL increment err_count (no wrap past 255) and clear pass; fail_addr SHALL be captured only on the first mismatch.
REQ-027 SHALL make the last RD_UP compare occur in the first WR_DN cycle and the last RD_DN compare in FIN, so no comparison is lost.
REQ-028 With ADDR_W=4, SHALL enter DONE (done=1, busy=0, ram_we=0) exactly 65 edges after E0.
REQ-029 SHALL ignore start while busy=1.
REQ-030 start=1 in DONE SHALL restart at WR_UP per REQ-019.
REQ-031 The address counter SHALL NOT wrap within a phase; the phase change occurs on the terminal address.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0, and clear the compare pipeline.
REQ-033 Reset mid-test SHALL abort with no further RAM writes; a fresh start SHALL be required afterwards.

Verification
REQ-034 Good RAM model, start pulse -> 64 RAM accesses in the order of REQ-020..023; done=1 at edge 65; pass=1; err_count=0.
REQ-035 RAM model with bit 0 of addr 7 stuck at 0 -> pat0(7)=8'hA2 reads correctly, pat1(7)=8'h5D reads 8'h5C; err_count=1; fail_addr=7; pass=0.
REQ-036 RAM model with addr 3 and 9 dout forced to 8'h00 -> err_count=4; fail_addr=3 (first hit in RD_UP).
REQ-037 RAM model returning 8'hFF always -> err_count=32; fail_addr=0; pass=0.
REQ-038 start held high during the test -> no restart; done at edge 65; in DONE with start high -> restart with done=0 and err_count=0.
REQ-039 rst asserted during WR_DN at addr 10 -> ram_we=0 and busy=0 with no clock edge; no writes until the next start.
